// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-like bus between the CPU EX/MEM stages and a responder.
// The master issues requests; the slave acknowledges with addr_ok and data_ok.
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_wstrb,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_wstrb,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Fixed-latency in-order data SRAM responder with a small request queue.
// Serves as core-level memory model and MEM-stage stall injection point.
module data_sram_responder #(
  parameter int AW          = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 resp_hold,
  data_sram_responder_if.slave bus
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [TW-1:0] timer;
  } ent_t;

  ent_t                   q [OUTSTANDING];
  logic [OUTSTANDING-1:0] vld;
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;
  logic [31:0]            mem [0:(1<<AW)-1];

  ent_t head_e;
  logic accept;
  logic pop;
  logic unused_bits;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_e = q[head];

  assign bus.data_sram_addr_ok =
    (count < CW'(OUTSTANDING)) && !resp_hold;

  assign bus.data_sram_data_ok =
    vld[head] && (head_e.timer == '0) && !resp_hold;

  assign accept = bus.data_sram_req && bus.data_sram_addr_ok;
  assign pop    = bus.data_sram_data_ok;

  // Reads are combinational so a write popped last cycle is visible now.
  assign bus.data_sram_rdata =
    (pop && !head_e.wr) ? mem[head_e.addr] : 32'h0;

  assign unused_bits = ^{bus.data_sram_size,
                         bus.data_sram_addr[31:AW+2],
                         bus.data_sram_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (vld[i] && q[i].timer != '0 && !resp_hold) begin
          q[i].timer <= q[i].timer - TW'(1);
        end
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= nxt(head);
      end
      // The tail slot is always free here, so no conflict with the decrement.
      if (accept) begin
        q[tail] <= '{wr:    bus.data_sram_wr,
                     addr:  bus.data_sram_addr[AW+1:2],
                     wdata: bus.data_sram_wdata,
                     wstrb: bus.data_sram_wstrb,
                     timer: TW'(LATENCY - 1)};
        vld[tail] <= 1'b1;
        tail      <= nxt(tail);
      end
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pop && head_e.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_e.wstrb[b]) begin
          mem[head_e.addr][8*b +: 8] <= head_e.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (LATENCY 2, 3, 1) checked
// against directed expectations and a queue-based reference model.
module tb_data_sram_responder;

  localparam int N   = 3;
  localparam int OUT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0] req;
  logic [N-1:0] wr;
  logic [N-1:0] hold;
  logic [1:0]   size  [N];
  logic [3:0]   wstrb [N];
  logic [31:0]  addr  [N];
  logic [31:0]  wdata [N];

  logic [N-1:0]       aok;
  logic [N-1:0]       dok;
  logic [N-1:0][31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    data_sram_responder_if bus ();
    assign bus.data_sram_req   = req[g];
    assign bus.data_sram_wr    = wr[g];
    assign bus.data_sram_size  = size[g];
    assign bus.data_sram_wstrb = wstrb[g];
    assign bus.data_sram_addr  = addr[g];
    assign bus.data_sram_wdata = wdata[g];
    assign aok[g]   = bus.data_sram_addr_ok;
    assign dok[g]   = bus.data_sram_data_ok;
    assign rdata[g] = bus.data_sram_rdata;

    data_sram_responder #(
      .AW(10), .LATENCY(L), .OUTSTANDING(OUT)
    ) dut (
      .clk(clk),
      .reset(reset),
      .resp_hold(hold[g]),
      .bus(bus.slave)
    );
  end

  // Reference model: a FIFO of pending requests, each with cycles remaining.
  typedef struct packed {
    logic        wr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [7:0]  rem;
  } mreq_t;

  mreq_t       mq   [N][$];
  logic [31:0] mmem [N][1024];

  function automatic int lat(int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  function automatic logic exp_aok(int k);
    return (mq[k].size() < OUT) && !hold[k];
  endfunction

  function automatic logic exp_dok(int k);
    if (mq[k].size() == 0 || hold[k]) return 1'b0;
    return mq[k][0].rem == 0;
  endfunction

  function automatic logic [31:0] exp_rdata(int k);
    if (!exp_dok(k) || mq[k][0].wr) return 32'h0;
    return mmem[k][mq[k][0].a];
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int k = 0; k < N; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < N; k++) begin
        automatic logic  ea = exp_aok(k);
        automatic logic  ed = exp_dok(k);
        automatic mreq_t e;
        if (ed) begin
          e = mq[k].pop_front();
          if (e.wr)
            for (int b = 0; b < 4; b++)
              if (e.s[b]) mmem[k][e.a][8*b +: 8] = e.d[8*b +: 8];
        end
        if (!hold[k])
          for (int i = 0; i < mq[k].size(); i++)
            if (mq[k][i].rem != 0) mq[k][i].rem = mq[k][i].rem - 8'd1;
        if (req[k] && ea) begin
          e = '{wr: wr[k], a: addr[k][11:2], d: wdata[k],
                s: wstrb[k], rem: 8'(lat(k) - 1)};
          mq[k].push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int k, logic w, logic [31:0] a,
                       logic [31:0] d, logic [3:0] s);
    req[k]   = 1'b1;
    wr[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    size[k]  = 2'd2;
    tick();
    req[k] = 1'b0;
  endtask

  task automatic wait_dok(int k, output int n, output logic [31:0] rd);
    n  = -1;
    rd = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dok[k]) begin
        n  = i;
        rd = rdata[k];
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (aok[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_addr_ok[%0d] got %b exp 1", k, aok[k]);
      end
      checks++;
      if (dok[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_data_ok[%0d] got %b exp 0", k, dok[k]);
      end
      checks++;
      if (rdata[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata[%0d] got %h exp 0", k, rdata[k]);
      end
    end
    hold[0] = 1'b1;
    #1;
    checks++;
    if (aok[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_addr_ok got %b exp 0", aok[0]);
    end
    hold[0] = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int n;
    logic [31:0] rd;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_dok(0, n, rd);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL wr_latency got %0d exp 2", n);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL wr_rdata got %h exp 0", rd);
    end
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_dok(0, n, rd);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL rd_latency got %0d exp 2", n);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data got %h exp deadbeef", rd);
    end
  endtask

  task automatic test_byte_strobe();
    int n;
    logic [31:0] rd;
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    wait_dok(0, n, rd);
    issue(0, 1'b1, 32'h20, 32'h00AA0000, 4'b0100);
    wait_dok(0, n, rd);
    issue(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    wait_dok(0, n, rd);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL zero_strobe_latency got %0d exp 2", n);
    end
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_dok(0, n, rd);
    checks++;
    if (rd !== 32'h11AA3344) begin
      errors++;
      $display("FAIL byte_strobe got %h exp 11aa3344", rd);
    end
  endtask

  task automatic test_queue_full();
    int n;
    logic [31:0] rd;
    logic [31:0] vals [3];
    int acc [3];
    int dcyc [$];
    logic [31:0] rds [$];
    logic [15:0] ahist;
    int sent;
    int ec [3];
    ec = '{3, 4, 7};
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      issue(1, 1'b1, 32'h40 + 32'(4 * i), vals[i], 4'hF);
      wait_dok(1, n, rd);
    end
    sent   = 0;
    ahist  = '0;
    acc    = '{-1, -1, -1};
    req[1] = 1'b1;
    wr[1]  = 1'b0;
    addr[1] = 32'h40;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (aok[1] !== exp_aok(1) || dok[1] !== exp_dok(1) ||
          rdata[1] !== exp_rdata(1)) begin
        errors++;
        $display("FAIL qfull_model c%0d got %b%b %h exp %b%b %h", c,
                 aok[1], dok[1], rdata[1],
                 exp_aok(1), exp_dok(1), exp_rdata(1));
      end
      ahist[c] = aok[1];
      if (dok[1]) begin
        dcyc.push_back(c);
        rds.push_back(rdata[1]);
      end
      if (req[1] && aok[1]) acc[sent++] = c;
      tick();
      if (sent < 3) addr[1] = 32'h40 + 32'(4 * sent);
      else req[1] = 1'b0;
    end
    checks++;
    if (ahist[2] !== 1'b0 || ahist[3] !== 1'b0) begin
      errors++;
      $display("FAIL qfull_addr_ok got %b%b exp 00", ahist[2], ahist[3]);
    end
    checks++;
    if (acc[0] != 0 || acc[1] != 1 || acc[2] != 4) begin
      errors++;
      $display("FAIL qfull_accept got %0d %0d %0d exp 0 1 4",
               acc[0], acc[1], acc[2]);
    end
    checks++;
    if (dcyc.size() != 3) begin
      errors++;
      $display("FAIL qfull_resp_count got %0d exp 3", dcyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dcyc[i] != ec[i] || rds[i] !== vals[i]) begin
          errors++;
          $display("FAIL qfull_resp%0d got c%0d %h exp c%0d %h",
                   i, dcyc[i], rds[i], ec[i], vals[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] rd;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    hold[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dok[0] !== 1'b0 || aok[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got ok %b%b exp 00", i, aok[0], dok[0]);
      end
      @(posedge clk);
    end
    #1 hold[0] = 1'b0;
    wait_dok(0, n, rd);
    checks++;
    if (n + 4 !== 6 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hold_latency got %0d %h exp 6 deadbeef", n + 4, rd);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] rd;
    logic [31:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      issue(2, 1'b1, 32'(4 * i), vals[i], 4'hF);
      wait_dok(2, n, rd);
    end
    req[2]  = 1'b1;
    wr[2]   = 1'b0;
    addr[2] = 32'h0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (aok[2] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_addr_ok%0d got %b exp 1", i, aok[2]);
        end
      end
      if (i > 0) begin
        checks++;
        if (dok[2] !== 1'b1 || rdata[2] !== vals[i-1]) begin
          errors++;
          $display("FAIL b2b_resp%0d got %b %h exp 1 %h",
                   i - 1, dok[2], rdata[2], vals[i-1]);
        end
      end
      tick();
      if (i < 7) addr[2] = 32'(4 * (i + 1));
      else req[2] = 1'b0;
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    logic [31:0] rd;
    req[0]   = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = 32'h10;
    wdata[0] = 32'h0;
    wstrb[0] = 4'hF;
    tick();
    wr[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    reset  = 1'b1;
    #1;
    checks++;
    if (dok[0] !== 1'b0 || aok[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_now got ok %b%b exp 10", aok[0], dok[0]);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (dok[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_dok%0d got %b exp 0", i, dok[0]);
      end
    end
    tick();
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_dok(0, n, rd);
    checks++;
    if (n !== 2 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midreset_lost_write got %0d %h exp 2 deadbeef", n, rd);
    end
  endtask

  task automatic test_random(int k);
    int n;
    logic [31:0] rd;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      issue(k, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF);
      wait_dok(k, n, rd);
    end
    for (int c = 0; c < 330; c++) begin
      if (c < 300) begin
        r        = $urandom;
        req[k]   = ($urandom_range(0, 9) < 7);
        wr[k]    = r[31];
        addr[k]  = {r[31:12], 7'b0000010, 3'($urandom_range(0, 7)), r[1:0]};
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
        size[k]  = 2'($urandom);
        hold[k]  = ($urandom_range(0, 9) == 0);
      end else begin
        req[k]  = 1'b0;
        hold[k] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (aok[k] !== exp_aok(k) || dok[k] !== exp_dok(k) ||
          rdata[k] !== exp_rdata(k)) begin
        errors++;
        $display("FAIL rand%0d c%0d got %b%b %h exp %b%b %h", k, c,
                 aok[k], dok[k], rdata[k],
                 exp_aok(k), exp_dok(k), exp_rdata(k));
      end
      tick();
    end
  endtask

  initial begin
    req  = '0;
    wr   = '0;
    hold = '0;
    for (int k = 0; k < N; k++) begin
      size[k]  = 2'd0;
      wstrb[k] = 4'h0;
      addr[k]  = 32'h0;
      wdata[k] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_queue_full();
    test_hold();
    test_back_to_back();
    test_reset_midflight();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
